// File: rtl/sr_drive_ctrl.sv
// -----------------------------------------------------------------------------
// sr_drive_ctrl
//
// Purpose:
//   Drives the S and R inputs of a downstream gated SR latch from single-cycle
//   set/clear command requests. Each accepted command holds S (or R) high for
//   PULSE_W clock cycles. A one-cycle gap with both drives low follows. An
//   optional check state then compares the latch Q feedback against the
//   expected state. S and R are never asserted together, so the invalid latch
//   condition is never driven.
//
// Optional feature:
//   SR_FB_CHECK_EN - when defined, adds the CHECK state, q_fb sampling and the
//                    sticky mismatch flag. Each command is then busy for
//                    PULSE_W+2 cycles. When undefined, GAP returns directly to
//                    IDLE, q_fb is ignored, mismatch is tied low, and each
//                    command is busy for PULSE_W+1 cycles.
//
// Parameters:
//   PULSE_W       - cycles S/R is held high per command (1..255)
//
// Ports:
//   clk           in   clock, all state changes on the rising edge
//   rst_n         in   asynchronous active-low reset
//   set_req       in   set-command request
//   clr_req       in   clear-command request
//   q_fb          in   Q feedback from the latch
//   S             out  registered set drive
//   R             out  registered reset drive
//   busy          out  high whenever the FSM is not idle
//   q_exp         out  latch state expected after the last accepted command
//   err_conflict  out  one-cycle pulse: set_req and clr_req together in IDLE
//   ovr           out  one-cycle pulse: request dropped because busy
//   mismatch      out  sticky: feedback disagreed with q_exp at CHECK
// -----------------------------------------------------------------------------
module sr_drive_ctrl #(
    parameter int unsigned PULSE_W = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set_req,
    input  logic clr_req,
    input  logic q_fb,
    output logic S,
    output logic R,
    output logic busy,
    output logic q_exp,
    output logic err_conflict,
    output logic ovr,
    output logic mismatch
);

    localparam int unsigned CNT_W = $clog2(PULSE_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_DRIVE_S = 3'd1;
    localparam logic [2:0] ST_DRIVE_R = 3'd2;
    localparam logic [2:0] ST_GAP     = 3'd3;
`ifdef SR_FB_CHECK_EN
    localparam logic [2:0] ST_CHECK   = 3'd4;
`endif

    // Reject out-of-range pulse widths at elaboration time.
    generate
        if ((PULSE_W < 1) || (PULSE_W > 255)) begin : g_bad_pulse_w
            $error("sr_drive_ctrl: PULSE_W must be in 1..255");
        end
    endgenerate

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             s_q,     s_d;
    logic             r_q,     r_d;
    logic             busy_q,  busy_d;
    logic             q_exp_q, q_exp_d;
    logic             err_q,   err_d;
    logic             ovr_q,   ovr_d;

`ifdef SR_FB_CHECK_EN
    logic             mism_q,  mism_d;
`endif

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_exp_d = q_exp_q;
        err_d   = 1'b0;
        ovr_d   = 1'b0;
`ifdef SR_FB_CHECK_EN
        mism_d  = mism_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (set_req && clr_req) begin
                    // Ambiguous command: flag it and stay idle, q_exp untouched.
                    err_d = 1'b1;
                end else if (set_req) begin
                    state_d = ST_DRIVE_S;
                    cnt_d   = '0;
                    q_exp_d = 1'b1;
                end else if (clr_req) begin
                    state_d = ST_DRIVE_R;
                    cnt_d   = '0;
                    q_exp_d = 1'b0;
                end
            end

            ST_DRIVE_S, ST_DRIVE_R: begin
                // cnt_q counts completed drive cycles; leave after the last one.
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_GAP: begin
`ifdef SR_FB_CHECK_EN
                state_d = ST_CHECK;
`else
                state_d = ST_IDLE;
`endif
            end

`ifdef SR_FB_CHECK_EN
            ST_CHECK: begin
                // The latch has had the whole gap cycle to settle.
                if (q_fb != q_exp_q) begin
                    mism_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
`endif

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Any request seen outside IDLE is dropped, including the edge on
        // which the FSM returns to IDLE.
        if ((state_q != ST_IDLE) && (set_req || clr_req)) begin
            ovr_d = 1'b1;
        end

        // Outputs are decoded from the next state so they are registered
        // yet still line up with the state they describe.
        s_d    = (state_d == ST_DRIVE_S);
        r_d    = (state_d == ST_DRIVE_R);
        busy_d = (state_d != ST_IDLE);
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            s_q     <= 1'b0;
            r_q     <= 1'b0;
            busy_q  <= 1'b0;
            q_exp_q <= 1'b0;
            err_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            r_q     <= r_d;
            busy_q  <= busy_d;
            q_exp_q <= q_exp_d;
            err_q   <= err_d;
            ovr_q   <= ovr_d;
        end
    end

`ifdef SR_FB_CHECK_EN
    // Sticky flag: only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mism_q <= 1'b0;
        end else begin
            mism_q <= mism_d;
        end
    end

    assign mismatch = mism_q;
`else
    // Feedback is not examined in this build.
    logic unused_q_fb;
    assign unused_q_fb = q_fb;
    assign mismatch    = 1'b0;
`endif

    assign S            = s_q;
    assign R            = r_q;
    assign busy         = busy_q;
    assign q_exp        = q_exp_q;
    assign err_conflict = err_q;
    assign ovr          = ovr_q;

endmodule

// File: tb/tb_sr_drive_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sr_drive_ctrl
//
// Directed bench for sr_drive_ctrl with PULSE_W=2. A simple latch model
// supplies q_fb; it can be forced low to provoke a feedback mismatch.
// Expectations follow SR_FB_CHECK_EN when that macro is defined.
// -----------------------------------------------------------------------------
module tb_sr_drive_ctrl;

    localparam int unsigned PW = 2;
`ifdef SR_FB_CHECK_EN
    localparam int BUSY_CYC = PW + 2;
    localparam int EXP_MIS  = 1;
`else
    localparam int BUSY_CYC = PW + 1;
    localparam int EXP_MIS  = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic set_req = 1'b0;
    logic clr_req = 1'b0;
    logic q_fb;
    logic S, R, busy, q_exp, err_conflict, ovr, mismatch;

    logic lq = 1'b0;
    logic fb_force0 = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Latch model: follows S/R on the clock; q_fb can be forced to 0.
    always @(posedge clk) begin
        if (S)      lq <= 1'b1;
        else if (R) lq <= 1'b0;
    end
    assign q_fb = fb_force0 ? 1'b0 : lq;

    sr_drive_ctrl #(.PULSE_W(PW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .set_req      (set_req),
        .clr_req      (clr_req),
        .q_fb         (q_fb),
        .S            (S),
        .R            (R),
        .busy         (busy),
        .q_exp        (q_exp),
        .err_conflict (err_conflict),
        .ovr          (ovr),
        .mismatch     (mismatch)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Issue a one-cycle request, then count S, R and busy cycles until idle.
    task automatic run_cmd(input logic s, input logic c,
                           output int s_n, output int r_n, output int b_n);
        set_req = s;
        clr_req = c;
        tick();
        set_req = 1'b0;
        clr_req = 1'b0;
        s_n = 0; r_n = 0; b_n = 0;
        for (int i = 0; (i < 20) && busy; i++) begin
            s_n += int'(S);
            r_n += int'(R);
            b_n++;
            if (S && R) chk("s_and_r_together", 32'd1, 32'd0);
            tick();
        end
    endtask

    int sc, rc, bc;

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_S", S, 0);
        chk("rst_R", R, 0);
        chk("rst_busy", busy, 0);
        chk("rst_q_exp", q_exp, 0);
        chk("rst_err", err_conflict, 0);
        chk("rst_ovr", ovr, 0);
        chk("rst_mismatch", mismatch, 0);

        // Set command issued on the first edge after reset release
        rst_n = 1'b1;
        run_cmd(1'b1, 1'b0, sc, rc, bc);
        chk("set_s_cycles", sc, PW);
        chk("set_r_cycles", rc, 0);
        chk("set_busy_cycles", bc, BUSY_CYC);
        chk("set_q_exp", q_exp, 1);
        chk("set_mismatch", mismatch, 0);

        // Conflict in IDLE: q_exp must stay 1
        set_req = 1'b1;
        clr_req = 1'b1;
        tick();
        set_req = 1'b0;
        clr_req = 1'b0;
        chk("conf_err", err_conflict, 1);
        chk("conf_S", S, 0);
        chk("conf_R", R, 0);
        chk("conf_busy", busy, 0);
        chk("conf_q_exp", q_exp, 1);
        tick();
        chk("conf_err_clear", err_conflict, 0);

        // Clear command with matching feedback
        run_cmd(1'b0, 1'b1, sc, rc, bc);
        chk("clr_r_cycles", rc, PW);
        chk("clr_s_cycles", sc, 0);
        chk("clr_busy_cycles", bc, BUSY_CYC);
        chk("clr_q_exp", q_exp, 0);
        chk("clr_mismatch", mismatch, 0);

        // Clear request during DRIVE_S is dropped
        set_req = 1'b1;
        tick();
        set_req = 1'b0;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        chk("ovr_pulse", ovr, 1);
        chk("ovr_S", S, 1);
        chk("ovr_R", R, 0);
        rc = 0;
        tick();
        chk("ovr_clear", ovr, 0);
        for (int i = 0; (i < 20) && busy; i++) begin
            rc += int'(R);
            tick();
        end
        chk("ovr_no_r", rc, 0);
        chk("ovr_busy_end", busy, 0);
        chk("ovr_q_exp", q_exp, 1);

        // Request on the edge where FSM returns to IDLE is dropped;
        // holding it makes the next (IDLE) edge accept it.
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int i = 1; i < BUSY_CYC; i++) tick();
        chk("last_busy", busy, 1);
        set_req = 1'b1;
        tick();
        chk("ret_ovr", ovr, 1);
        chk("ret_busy", busy, 0);
        chk("ret_S", S, 0);
        chk("ret_q_exp", q_exp, 0);
        tick();
        set_req = 1'b0;
        chk("accept_S", S, 1);
        chk("accept_ovr", ovr, 0);
        chk("accept_q_exp", q_exp, 1);
        for (int i = 0; (i < 20) && busy; i++) tick();
        chk("accept_idle", busy, 0);

        // Forced-low feedback, then a correct command, then reset
        fb_force0 = 1'b1;
        run_cmd(1'b1, 1'b0, sc, rc, bc);
        fb_force0 = 1'b0;
        chk("mis_set", mismatch, EXP_MIS);
        chk("mis_busy_cycles", bc, BUSY_CYC);
        run_cmd(1'b0, 1'b1, sc, rc, bc);
        chk("mis_sticky", mismatch, EXP_MIS);
        chk("mis_q_exp", q_exp, 0);
        rst_n = 1'b0;
        #1;
        chk("mis_rst_clear", mismatch, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Asynchronous reset during the second DRIVE_S cycle
        set_req = 1'b1;
        tick();
        set_req = 1'b0;
        tick();
        chk("abort_S_before", S, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_S", S, 0);
        chk("abort_busy", busy, 0);
        chk("abort_q_exp", q_exp, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("abort_no_resume_busy", busy, 0);
        chk("abort_no_resume_S", S, 0);
        chk("abort_no_resume_mis", mismatch, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sr_drive_ctrl.md
SR_DRIVE_CTRL -- requirements
Module: sr_drive_ctrl

Interface
REQ-001 Parameter PULSE_W, default 2, is the number of clk cycles S or R is held high per command, with a legal range of 1..255.
REQ-002 clk  input  1  is the single clock; all state updates occur on its rising edge.
REQ-003 rst_n  input  1  is the reset, asynchronous and active-low.
REQ-004 set_req  input  1  is a set-command request, sampled on the rising edge of clk.
REQ-005 clr_req  input  1  is a reset-command request, sampled on the rising edge of clk.
REQ-006 q_fb  input  1  is the Q feedback from the downstream gated SR latch.
REQ-007 S  output  1  is the registered set drive to the latch.
REQ-008 R  output  1  is the registered reset drive to the latch.
REQ-009 busy  output  1  is high whenever the FSM is not in IDLE.
REQ-010 q_exp  output  1  holds the latch state expected after the last accepted command.
REQ-011 err_conflict  output  1  is a one-cycle pulse flagging simultaneous set_req and clr_req.
REQ-012 ovr  output  1  is a one-cycle pulse flagging a request dropped while busy.
REQ-013 mismatch  output  1  is a sticky flag set when q_fb disagrees with q_exp at CHECK.

Function
REQ-014 The block SHALL implement FSM states IDLE, DRIVE_S, DRIVE_R, GAP and CHECK.
REQ-015 All outputs SHALL be registered; no output SHALL depend combinationally on any input.
REQ-016 In IDLE, set_req=1 with clr_req=0 SHALL move the FSM to DRIVE_S and set q_exp=1, so S=1 is visible in the cycle after sampling.
REQ-017 In IDLE, clr_req=1 with set_req=0 SHALL move the FSM to DRIVE_R and set q_exp=0, so R=1 is visible in the cycle after sampling.
REQ-018 In IDLE, set_req=1 together with clr_req=1 SHALL pulse err_conflict for one cycle, keep the FSM in IDLE, drive S=R=0 and leave q_exp unchanged.
REQ-019 S SHALL be high only in DRIVE_S and R SHALL be high only in DRIVE_R, so S and R are never high together (the invalid latch state is never driven).
REQ-020 DRIVE_S and DRIVE_R SHALL each last exactly PULSE_W cycles, counted by a counter of width $clog2(PULSE_W+1) that is cleared on entry.
REQ-021 After DRIVE_S or DRIVE_R the FSM SHALL enter GAP for exactly one cycle with S=R=0.
REQ-022 Any set_req or clr_req sampled while busy=1 SHALL be dropped and SHALL pulse ovr for one cycle; a drop never affects S, R or q_exp.
REQ-023 A request sampled in the same edge where the FSM returns to IDLE SHALL be treated as busy and dropped; the first acceptable edge is the one where the FSM is in IDLE.
REQ-024 busy SHALL be 0 in IDLE and 1 in every other state.
REQ-025 With SR_FB_CHECK_EN defined, GAP SHALL go to CHECK, CHECK SHALL compare q_fb against q_exp for one cycle, set mismatch on disagreement and then go to IDLE.
REQ-026 mismatch SHALL stay set until rst_n is asserted and SHALL never be cleared by later matches.

Reset
REQ-027 When rst_n=0, the block SHALL immediately, independent of clk, force the FSM to IDLE, S=0, R=0, busy=0, q_exp=0, err_conflict=0, ovr=0, mismatch=0 and the pulse counter to 0.
REQ-028 A reset asserted mid-drive SHALL abort the command with no completion, GAP or CHECK.
REQ-029 The first request SHALL be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-030 The feedback check SHALL be controlled by macro SR_FB_CHECK_EN.
REQ-031 With SR_FB_CHECK_EN defined, the CHECK state, q_fb sampling and mismatch logic SHALL be present, for a total of PULSE_W+2 busy cycles per command.
REQ-032 Without SR_FB_CHECK_EN, CHECK SHALL be absent, GAP SHALL go directly to IDLE, mismatch SHALL be tied to 0, q_fb SHALL be ignored, and each command SHALL occupy PULSE_W+1 busy cycles.

Verification (PULSE_W=2, SR_FB_CHECK_EN defined unless stated)
REQ-033 A one-cycle set_req pulse SHALL give S=1 for 2 cycles, then a 1-cycle GAP, then CHECK, then IDLE; R=0 throughout, q_exp=1, busy high for 4 cycles.
REQ-034 A clr_req pulse with the latch model returning q_fb=0 SHALL give R=1 for 2 cycles, q_exp=0 and mismatch=0.
REQ-035 set_req and clr_req raised on the same edge in IDLE SHALL give err_conflict=1 for one cycle, S=R=0 and busy=0.
REQ-036 A set_req followed by a clr_req issued during DRIVE_S SHALL give ovr=1 for one cycle, no R pulse ever, and q_exp=1.
REQ-037 A set_req with q_fb forced to 0 SHALL set mismatch=1 at CHECK; a following correct command SHALL leave mismatch=1; rst_n=0 SHALL then clear mismatch to 0.
REQ-038 rst_n driven low during the second DRIVE_S cycle SHALL drop S to 0 asynchronously and bring busy=0 and q_exp=0; with the macro undefined, a set command SHALL give busy for 3 cycles and mismatch=0 even with q_fb=0.
